// File: rtl/reg_bank_write_port.sv
// reg_bank_write_port: write side of the 4-entry register bank.
// Requests arrive over a valid/ready handshake, wait one edge in a
// single-entry pending buffer, then commit to the selected register
// unless commit_stall holds them.
// Optional build macro: R00_ZERO_EN (R00 hardwired to zero).
module reg_bank_write_port #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit_stall,
    output logic [DATA_W-1:0] R00,
    output logic [DATA_W-1:0] R01,
    output logic [DATA_W-1:0] R02,
    output logic [DATA_W-1:0] R03,
    output logic              pend_busy,
    output logic [SEL_W-1:0]  pend_sel,
    output logic              err_oob,
    output logic [7:0]        wr_count
);

`ifdef R00_ZERO_EN
    localparam bit R00_HARDWIRED = 1'b1;
`else
    localparam bit R00_HARDWIRED = 1'b0;
`endif

    localparam logic [SEL_W-1:0] NUM_REGS_SEL = SEL_W'(NUM_REGS);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SEL_W-1:0]    pend_sel_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic [DATA_W-1:0]   regs [4];
    logic                err_oob_q;
    logic [7:0]          wr_count_q;

    logic                accept;
    logic                commit;
    logic                in_range;

    // Handshake and commit qualification.
    always_comb begin
        pend_busy = (state_q == ST_FULL);
        wr_ready  = !pend_busy || !commit_stall;
        accept    = wr_valid && wr_ready;
        commit    = pend_busy && !commit_stall;
        in_range  = (pend_sel_q < NUM_REGS_SEL);
    end

    // Pending-buffer occupancy: a new accept refills it even while the old entry commits.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_FULL;
        end else if (commit) begin
            state_d = ST_EMPTY;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending select/data; select returns to 0 once the buffer drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_sel_q  <= '0;
            pend_data_q <= '0;
        end else if (accept) begin
            pend_sel_q  <= wr_sel;
            pend_data_q <= wr_data;
        end else if (commit) begin
            pend_sel_q  <= '0;
        end
    end

    // One-hot commit into the implemented registers; R00 is skipped when hardwired.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if ((i < NUM_REGS) && (pend_sel_q == SEL_W'(i)) &&
                    !(R00_HARDWIRED && (i == 0))) begin
                    regs[i] <= pend_data_q;
                end
            end
        end
    end

    // Out-of-range pulse and in-range commit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_oob_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            err_oob_q <= commit && !in_range;
            if (commit && in_range) begin
                wr_count_q <= wr_count_q + 8'd1;
            end
        end
    end

    // Output mapping; unimplemented registers read as constant zero.
    always_comb begin
        R00      = (R00_HARDWIRED || (NUM_REGS < 1)) ? '0 : regs[0];
        R01      = (NUM_REGS > 1) ? regs[1] : '0;
        R02      = (NUM_REGS > 2) ? regs[2] : '0;
        R03      = (NUM_REGS > 3) ? regs[3] : '0;
        pend_sel = pend_busy ? pend_sel_q : '0;
        err_oob  = err_oob_q;
        wr_count = wr_count_q;
    end

endmodule

// File: doc/reg_bank_write_port.md
Name: reg_bank_write_port

Overview:
- Write side of the 4-entry 32-bit register bank. Its R00..R03 outputs feed the bank's 5-bit-select read mux.
- Accepts write requests through a valid/ready handshake and holds each one in a single-entry pending buffer.
- Commits the pending write to the selected register on the next clock edge unless the control unit stalls it.
- Exposes pending-write status so readers can detect a read-after-write hazard.

Parameters:
- DATA_W, 32, width of each register and of wr_data.
- SEL_W, 5, width of wr_sel; matches the read mux select.
- NUM_REGS, 4, number of implemented registers (legal range 1..4). Select values >= NUM_REGS are out of range.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  block can accept a request this cycle.
- wr_sel  input  SEL_W  target register index.
- wr_data  input  DATA_W  write data.
- commit_stall  input  1  holds the pending write without committing it.
- R00, R01, R02, R03  output  DATA_W each  committed register contents; unimplemented registers read 0.
- pend_busy  output  1  pending buffer holds an uncommitted write.
- pend_sel  output  SEL_W  index of the pending write; 0 when not busy.
- err_oob  output  1  one-cycle pulse when an out-of-range write is dropped.
- wr_count  output  8  number of successful commits; wraps 255 -> 0.

Behaviour:
- Reset, synchronous: R00..R03 = 0, pend_busy = 0, pend_sel = 0, err_oob = 0, wr_count = 0. Any pending write is discarded, not committed. The reset edge overrides every other event, including a simultaneous accept or commit.
- wr_ready = !pend_busy || !commit_stall. This is combinational and does not depend on wr_valid.
- Accept: wr_valid && wr_ready at a rising edge. wr_sel and wr_data are latched into the pending buffer and pend_busy = 1 after that edge.
- Commit: at any rising edge with pend_busy && !commit_stall, the pending data is written to register pend_sel.
  - Decode is one-hot over NUM_REGS.
  - The written value appears on its R output after that edge.
- Latency: accepted at edge k, committed at edge k+1 when unstalled; visible from cycle k+1 onward.
- Accept and commit at the same edge: legal, sustaining one write per cycle.
  - The old entry commits.
  - The new entry replaces it in the pending buffer.
  - pend_busy stays 1.
- Commit with no new accept: pend_busy goes to 0 and pend_sel goes to 0.
- Stall:
  - The pending entry holds unchanged; its data and select are frozen.
  - wr_ready = 0, so no request is accepted.
  - A requester holding wr_valid high must keep wr_sel and wr_data stable.
- Out-of-range commit (pend_sel >= NUM_REGS):
  - No register changes.
  - err_oob = 1 for exactly the cycle after the commit edge.
  - wr_count is not incremented.
  - The pending buffer empties normally.
- wr_count increments by 1 on every in-range commit, modulo 256.
- Registers with index >= NUM_REGS are constant 0 on their outputs.
- Only committed values appear on the R outputs; there is no internal bypass. Readers compare their select against pend_sel while pend_busy is 1 to detect a hazard.

Optional Feature:
- Macro: R00_ZERO_EN.
- Defined: R00 is hardwired to 0.
  - A commit to index 0 is accepted and completes, but leaves R00 at 0.
  - err_oob stays 0 for that commit.
  - wr_count still increments.
- Undefined: R00 is an ordinary writable register.

Test Plan:
1. Reset, then a single write: wr_valid = 1, wr_sel = 2, wr_data = 0xDEADBEEF for one cycle -> pend_busy = 1 and pend_sel = 2 in the next cycle; the cycle after, R02 = 0xDEADBEEF, pend_busy = 0, wr_count = 1. R00, R01 and R03 remain 0.
2. Back-to-back writes on consecutive cycles, sel 0/1/3 with data 0x11/0x22/0x33 -> wr_ready stays 1 throughout. R00 = 0x11, R01 = 0x22, R03 = 0x33 at one register per cycle; wr_count = 3. With R00_ZERO_EN defined, R00 = 0 and wr_count is still 3.
3. Stall hold: accept sel 1, data 0xA5A5A5A5, then hold commit_stall = 1 for 3 cycles while wr_valid = 1 with sel 3, data 0x5A -> wr_ready = 0 and R01 is unchanged during the stall. After the stall releases, R01 = 0xA5A5A5A5, then R03 = 0x5A on the next cycle.
4. Out-of-range: write sel 7, data 0xFFFFFFFF -> all registers unchanged, err_oob = 1 for one cycle, wr_count unchanged.
5. Reset mid-operation: accept sel 2, data 0x1234, and assert reset on the next edge -> R02 = 0, pend_busy = 0, wr_count = 0; the write is never committed.
6. Wrap: 256 in-range commits -> wr_count returns to 0 after the 256th commit; the last-written register holds the final data.
